// File: rtl/rsa_stream_pkg.sv
// Shared types and constants for the RSA byte-stream controller.
// Build option: define RSA_STREAM_FULL_OUT_EN to emit all 32 result bytes
// per block instead of 31. When it is defined, the top byte of the result
// is also sent.
package rsa_stream_pkg;

  // Operand geometry
  localparam int KEY_BYTES = 32;
  localparam int KEY_BITS  = 8 * KEY_BYTES;
  localparam int OUT_BYTES = 31;

`ifdef RSA_STREAM_FULL_OUT_EN
  localparam int EMIT_BYTES = KEY_BYTES;
`else
  localparam int EMIT_BYTES = OUT_BYTES;
`endif

  // Byte counter indexes 0..KEY_BYTES-1
  localparam int CNT_W = $clog2(KEY_BYTES);
  // Emit count must be able to hold KEY_BYTES itself
  localparam int EMIT_W = $clog2(KEY_BYTES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(KEY_BYTES - 1);
  localparam logic [EMIT_W-1:0] EMIT_COUNT = EMIT_W'(EMIT_BYTES);

  typedef enum logic [2:0] {
    S_GET_N = 3'd0,
    S_GET_D = 3'd1,
    S_GET_A = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_SEND  = 3'd5
  } state_e;

  // Big-endian assembly: the older bytes move up and the new byte enters at the bottom
  function automatic logic [KEY_BITS-1:0] shift_in_byte(
    input logic [KEY_BITS-1:0] word,
    input logic [7:0]          data
  );
    return {word[KEY_BITS-9:0], data};
  endfunction

  // Operand byte counter: advance and wrap to zero after the last byte
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
    if (cnt == CNT_LAST) begin
      nxt = {CNT_W{1'b0}};
    end else begin
      nxt = cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rsa_stream_ctrl_serializer.sv
// rsa_byte_serializer: takes a 256-bit word and the number of low-order
// bytes to send. It emits those bytes MSB first on a valid/ready byte stream.
// tx_data and tx_valid come from registers. done goes high in the same cycle
// as the final handshake, so the parent can move on at that clock edge.
module rsa_byte_serializer
  import rsa_stream_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [KEY_BITS-1:0] word,
  input  logic [EMIT_W-1:0]   byte_count,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                done
);

  logic [KEY_BITS-1:0] shift_r;
  logic [EMIT_W-1:0]   remaining_r;
  logic [7:0]          data_r;
  logic                valid_r;

  logic [8:0]          shamt_s;
  logic [KEY_BITS-1:0] aligned_s;
  logic                fire_s;
  logic                last_s;

  // Left-justify the word so the first byte to emit lands in the top lane
  always_comb begin
    shamt_s   = {EMIT_W'(KEY_BYTES) - byte_count, 3'b000};
    aligned_s = word << shamt_s;
  end

  assign fire_s = valid_r && tx_ready;
  assign last_s = (remaining_r == EMIT_W'(1));

  // Load a new word, or step to the next byte after each accepted handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r     <= {KEY_BITS{1'b0}};
      remaining_r <= {EMIT_W{1'b0}};
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
    end else if (load) begin
      data_r      <= aligned_s[KEY_BITS-1 -: 8];
      shift_r     <= {aligned_s[KEY_BITS-9:0], 8'h00};
      remaining_r <= byte_count;
      valid_r     <= (byte_count != {EMIT_W{1'b0}});
    end else if (fire_s) begin
      if (last_s) begin
        valid_r     <= 1'b0;
        remaining_r <= {EMIT_W{1'b0}};
      end else begin
        data_r      <= shift_r[KEY_BITS-1 -: 8];
        shift_r     <= {shift_r[KEY_BITS-9:0], 8'h00};
        remaining_r <= remaining_r - EMIT_W'(1);
      end
    end
  end

  assign tx_data  = data_r;
  assign tx_valid = valid_r;
  assign done     = fire_s && last_s;

endmodule

// File: rtl/rsa_stream_ctrl.sv
// rsa_stream_ctrl: host-side initiator for the 256-bit RSA core.
// It collects n, d and the ciphertext a as big-endian byte streams.
// It pulses the core start for one cycle and then waits for the finished pulse.
// After that it streams the plaintext out through rsa_byte_serializer.
// The key (n, d) is kept across blocks. When i_key_reload is raised at an
// operand boundary, the controller returns to collecting a new key.
// Build option: RSA_STREAM_FULL_OUT_EN (see rsa_stream_pkg) selects 32
// output bytes per block instead of 31.
module rsa_stream_ctrl
  import rsa_stream_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic         o_rx_ready,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  input  logic         i_key_reload,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished
);

  state_e              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [KEY_BITS-1:0] n_r;
  logic [KEY_BITS-1:0] d_r;
  logic [KEY_BITS-1:0] a_r;
  logic                start_r;

  logic                rx_ready_s;
  logic                rx_fire_s;
  logic                cnt_last_s;
  logic                reload_s;
  logic                ser_load_s;
  logic                ser_done_s;

  // Accept inbound bytes only while collecting an operand and no reload is requested
  always_comb begin
    rx_ready_s = 1'b0;
    case (state_r)
      S_GET_N, S_GET_D, S_GET_A: rx_ready_s = !i_key_reload;
      default:                   rx_ready_s = 1'b0;
    endcase
  end

  assign rx_fire_s  = rx_ready_s && i_rx_valid;
  assign cnt_last_s = (cnt_r == CNT_LAST);
  // A reload is honoured only on a ciphertext boundary
  assign reload_s   = i_key_reload && (cnt_r == {CNT_W{1'b0}});
  assign ser_load_s = (state_r == S_WAIT) && i_core_finished;

  // Main sequencer: operand assembly, start pulse, wait for core, hand off to TX
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= S_GET_N;
      cnt_r   <= {CNT_W{1'b0}};
      n_r     <= {KEY_BITS{1'b0}};
      d_r     <= {KEY_BITS{1'b0}};
      a_r     <= {KEY_BITS{1'b0}};
      start_r <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        S_GET_N: begin
          if (rx_fire_s) begin
            n_r   <= shift_in_byte(n_r, i_rx_data);
            cnt_r <= next_count(cnt_r);
            if (cnt_last_s) begin
              state_r <= S_GET_D;
            end
          end
        end
        S_GET_D: begin
          if (rx_fire_s) begin
            d_r   <= shift_in_byte(d_r, i_rx_data);
            cnt_r <= next_count(cnt_r);
            if (cnt_last_s) begin
              state_r <= S_GET_A;
            end
          end
        end
        S_GET_A: begin
          if (reload_s) begin
            // n/d keep their old values until the new key bytes replace them
            state_r <= S_GET_N;
          end else if (rx_fire_s) begin
            a_r   <= shift_in_byte(a_r, i_rx_data);
            cnt_r <= next_count(cnt_r);
            if (cnt_last_s) begin
              state_r <= S_START;
              start_r <= 1'b1;
            end
          end
        end
        S_START: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          // The serializer captures i_core_result on this same edge
          if (i_core_finished) begin
            state_r <= S_SEND;
          end
        end
        S_SEND: begin
          if (ser_done_s) begin
            state_r <= S_GET_A;
          end
        end
        default: begin
          state_r <= S_GET_N;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  rsa_byte_serializer u_serializer (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (ser_load_s),
    .word       (i_core_result),
    .byte_count (EMIT_COUNT),
    .tx_data    (o_tx_data),
    .tx_valid   (o_tx_valid),
    .tx_ready   (i_tx_ready),
    .done       (ser_done_s)
  );

  assign o_rx_ready   = rx_ready_s;
  assign o_core_start = start_r;
  assign o_core_a     = a_r;
  assign o_core_d     = d_r;
  assign o_core_n     = n_r;

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Scoreboard bench for rsa_stream_ctrl. The bench contains a behavioural RSA
// core that computes a^d mod n with wide arithmetic. Expected plaintext bytes
// are queued when the core finishes, and a separate monitor pops them on each
// TX handshake.
module tb_rsa_stream_ctrl;

  localparam int KB = 32;
`ifdef RSA_STREAM_FULL_OUT_EN
  localparam int EMIT = 32;
`else
  localparam int EMIT = 31;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [7:0]   i_rx_data;
  logic         i_rx_valid;
  logic         o_rx_ready;
  logic [7:0]   o_tx_data;
  logic         o_tx_valid;
  logic         i_tx_ready;
  logic         i_key_reload;
  logic         o_core_start;
  logic [255:0] o_core_a;
  logic [255:0] o_core_d;
  logic [255:0] o_core_n;
  logic [255:0] i_core_result;
  logic         i_core_finished;

  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  int stall_cycles = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  rsa_stream_ctrl dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_rx_data       (i_rx_data),
    .i_rx_valid      (i_rx_valid),
    .o_rx_ready      (o_rx_ready),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .i_tx_ready      (i_tx_ready),
    .i_key_reload    (i_key_reload),
    .o_core_start    (o_core_start),
    .o_core_a        (o_core_a),
    .o_core_d        (o_core_d),
    .o_core_n        (o_core_n),
    .i_core_result   (i_core_result),
    .i_core_finished (i_core_finished)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference RSA: square-and-multiply using plain wide arithmetic
  function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                          input logic [255:0] m);
    logic [511:0] r, x, mm;
    mm = {256'd0, m};
    r  = 512'd1;
    x  = {256'd0, b} % mm;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Sink readiness: random back-pressure, or a forced stall window
  initial begin
    i_tx_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (stall_cycles > 0) begin
        i_tx_ready = 1'b0;
        stall_cycles--;
      end else begin
        i_tx_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: a byte transfers at the next rising edge when valid and ready are both high now
  always @(negedge i_clk) begin
    #2;
    if (!i_rst && o_tx_valid && i_tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got byte %02h, expected no output", o_tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", 256'(o_tx_data), 256'(mon_exp));
        tx_count++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    #1;
    while (!o_rx_ready && waited < 2000) begin
      @(negedge i_clk);
      #1;
      waited++;
    end
    if (!o_rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: o_rx_ready 0 after %0d cycles, expected 1", waited);
    end
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [255:0] w);
    for (int i = KB - 1; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_start(input logic [255:0] n, input logic [255:0] d, input logic [255:0] a);
    int waited;
    waited = 0;
    #1;
    while (!o_core_start && waited < 50) begin
      @(negedge i_clk);
      #1;
      waited++;
    end
    check("start_latency", 256'(waited), 256'd0);
    check("core_n", o_core_n, n);
    check("core_d", o_core_d, d);
    check("core_a", o_core_a, a);
    @(negedge i_clk);
    #1;
    check("start_width", 256'(o_core_start), 256'd0);
  endtask

  task automatic core_finish(input logic [255:0] res, input int delay,
                             input logic [255:0] n, input logic [255:0] d, input logic [255:0] a);
    for (int k = 0; k < EMIT; k++) exp_q.push_back(8'(res >> (8 * (EMIT - 1 - k))));
    repeat (delay) @(negedge i_clk);
    check("ops_stable", {o_core_n ^ n} | {o_core_d ^ d} | {o_core_a ^ a}, 256'd0);
    i_core_result   = res;
    i_core_finished = 1'b1;
    @(negedge i_clk);
    i_core_finished = 1'b0;
    #1;
    check("tx_latency", 256'(o_tx_valid), 256'd1);
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(negedge i_clk);
      waited++;
    end
    check("tx_drain", 256'(exp_q.size()), 256'd0);
    @(negedge i_clk);
  endtask

  task automatic run_block(input logic [255:0] n, input logic [255:0] d, input logic [255:0] a,
                           input bit drain);
    send_word(a);
    expect_start(n, d, a);
    core_finish(modexp(a, d, n), $urandom_range(1, 6), n, d, a);
    if (drain) wait_drain();
  endtask

  logic [255:0] n0, d0, n1, n2, d2, a, fixed;
  logic [7:0]   snap;
  int           base, waited;
  bit           saw_tx;

  initial begin
    i_rst = 1'b1;
    i_rx_data = 8'h00;
    i_rx_valid = 1'b0;
    i_key_reload = 1'b0;
    i_core_result = 256'd0;
    i_core_finished = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_core_a", o_core_a, 256'd0);
    check("rst_core_d", o_core_d, 256'd0);
    check("rst_core_n", o_core_n, 256'd0);
    check("rst_start", 256'(o_core_start), 256'd0);
    check("rst_tx_valid", 256'(o_tx_valid), 256'd0);
    check("rst_tx_data", 256'(o_tx_data), 256'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_rx_ready", 256'(o_rx_ready), 256'd1);
    @(negedge i_clk);

    // Key load, then a = 1 and a = 0
    n0 = rand256() | {1'b1, 255'd0} | 256'd1;
    d0 = rand256();
    send_word(n0);
    send_word(d0);
    run_block(n0, d0, 256'd1, 1'b1);
    run_block(n0, d0, 256'd0, 1'b1);

    // Five ciphertext blocks without waiting for each TX to drain
    for (int b = 0; b < 5; b++) run_block(n0, d0, rand256() >> 1, 1'b0);
    wait_drain();

    // Stall the sink for 5 cycles in the middle of a block with a known result
    for (int k = 0; k < 32; k++) fixed[8*k +: 8] = (k < EMIT) ? 8'(EMIT - 1 - k) : 8'hAA;
    a = rand256() >> 1;
    send_word(a);
    expect_start(n0, d0, a);
    base = tx_count;
    core_finish(fixed, 2, n0, d0, a);
    waited = 0;
    while (tx_count < base + 10 && waited < 2000) begin
      @(negedge i_clk);
      waited++;
    end
    stall_cycles = 5;
    @(posedge i_clk);
    #2;
    snap = o_tx_data;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk);
      #2;
      check("stall_data", 256'(o_tx_data), 256'(snap));
      check("stall_valid", 256'(o_tx_valid), 256'd1);
    end
    wait_drain();

    // Reload at counter 0: the byte presented with the reload is refused
    i_key_reload = 1'b1;
    i_rx_data = 8'hEE;
    i_rx_valid = 1'b1;
    #1;
    check("reload_ready", 256'(o_rx_ready), 256'd0);
    @(negedge i_clk);
    i_key_reload = 1'b0;
    i_rx_valid = 1'b0;
    n1 = rand256() | {1'b1, 255'd0} | 256'd1;
    send_word(n1);
    send_word(d0);
    run_block(n1, d0, rand256() >> 1, 1'b1);

    // Reload at counter 5 has no effect beyond holding off that one byte
    a = rand256() >> 1;
    for (int i = KB - 1; i >= KB - 5; i--) send_byte(a[8*i +: 8]);
    i_key_reload = 1'b1;
    i_rx_data = a[8*(KB-6) +: 8];
    i_rx_valid = 1'b1;
    #1;
    check("reload_mid_ready", 256'(o_rx_ready), 256'd0);
    @(negedge i_clk);
    i_key_reload = 1'b0;
    i_rx_valid = 1'b0;
    for (int i = KB - 6; i >= 0; i--) send_byte(a[8*i +: 8]);
    expect_start(n1, d0, a);
    core_finish(modexp(a, d0, n1), 3, n1, d0, a);
    wait_drain();

    // Reset while waiting on the core, then a stray finished pulse
    a = rand256() >> 1;
    send_word(a);
    expect_start(n1, d0, a);
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("wrst_core_n", o_core_n, 256'd0);
    check("wrst_core_a", o_core_a, 256'd0);
    check("wrst_tx_valid", 256'(o_tx_valid), 256'd0);
    check("wrst_rx_ready", 256'(o_rx_ready), 256'd1);
    @(negedge i_clk);
    i_core_result = rand256();
    i_core_finished = 1'b1;
    @(negedge i_clk);
    i_core_finished = 1'b0;
    saw_tx = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (o_tx_valid) saw_tx = 1'b1;
      @(negedge i_clk);
    end
    check("stray_finished_tx", 256'(saw_tx), 256'd0);

    // A fresh key and block decrypt correctly after the abort
    n2 = rand256() | {1'b1, 255'd0} | 256'd1;
    d2 = rand256();
    send_word(n2);
    send_word(d2);
    run_block(n2, d2, rand256() >> 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
